alu_decode_stage: RTL and testbench
===================================

// Module: alu_decode_stage
// PURPOSE
//  Decode/issue stage that produces the operand and control bundle consumed by the RV32I ALU.
//  - Accepts an instruction word with PC and register-file read data over a valid/ready handshake.
//  - Decodes OP, OP-IMM, LUI and AUIPC into alu_a, alu_b, alu_funct3 and alu_funct7.
//  - Delivers the bundle to the execute stage through a registered output with a 2-entry skid buffer.
//  - All outputs are registered, so no combinational path exists from any input to out_valid or in_ready.
// PARAMETERS
//  XLEN     32   datapath width; only 32 is supported (elaboration $error otherwise)
//  PC_W     32   PC width; zero-extended to XLEN when used as an operand
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      async active-low reset
//  in_valid     in   1      upstream bundle valid
//  in_ready     out  1      stage can accept (registered)
//  in_instr     in   32     instruction word
//  in_pc        in   PC_W   PC of instruction
//  in_rs1_data  in   XLEN   rs1 read data
//  in_rs2_data  in   XLEN   rs2 read data
//  flush        in   1      synchronous kill of all held entries
//  out_valid    out  1      decoded bundle valid
//  out_ready    in   1      execute stage accepts
//  alu_a        out  XLEN   ALU operand a
//  alu_b        out  XLEN   ALU operand b
//  alu_funct3   out  3      ALU op select
//  alu_funct7   out  7      ALU modifier; bit 5 selects SUB/SRA
//  rd           out  5      destination register
//  reg_write    out  1      writeback enable
//  illegal      out  1      unsupported opcode/funct encoding
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - out_valid=0, in_ready=1, both entries empty.
//   - All data outputs (alu_a, alu_b, alu_funct3, alu_funct7, rd, reg_write, illegal) = 0.
//  Handshake
//   - A transfer happens on an edge where valid&&ready. Inputs are stable only on that edge.
//   - Once raised, out_valid and the output bundle hold until out_ready.
//  Latency
//   - Accepted at edge N -> out_valid=1 after edge N when the output register is empty or draining.
//  Skid buffer
//   - When out_valid && !out_ready and a new input is accepted, it goes to the skid entry.
//   - in_ready = !skid_valid (registered).
//   - On drain, skid moves to the output register the same edge; order is strictly FIFO.
//  Simultaneous accept and drain with skid empty
//   - The output register takes the new bundle; out_valid stays 1.
//  Flush
//   - Clears out_valid and skid_valid at the edge.
//   - An input accepted on the flush edge is discarded.
//   - in_ready=1 on the following cycle.
//   - Flush overrides out_ready.
//  Decode (opcode = in_instr[6:0])
//   - OP 0110011:
//     - a=rs1, b=rs2, f3=instr[14:12], f7=instr[31:25].
//     - illegal unless f7 is 0000000, or f7 is 0100000 with f3 in {000,101}.
//   - OP-IMM 0010011:
//     - a=rs1, b=sext(instr[31:20]), f3=instr[14:12].
//     - f7=instr[31:25] only for f3 in {001,101}; otherwise f7=0, so ADDI never subtracts.
//     - SLLI: f7 must be 0. SRLI/SRAI: f7 must be 0000000 or 0100000. Otherwise illegal.
//   - LUI 0110111: a=0, b={instr[31:12],12'b0}, f3=000, f7=0.
//   - AUIPC 0010111: a=zext(pc), b={instr[31:12],12'b0}, f3=000, f7=0.
//   - rd = instr[11:7] for all opcodes.
//   - reg_write = !illegal && rd!=0.
//   - Any other opcode: illegal=1, reg_write=0, a=b=0, f3=f7=0; still delivered as a valid bundle.
//  Reset mid-operation
//   - Both entries are dropped immediately (async).
//   - No partial bundle is ever presented on out_valid.
// TESTING
//  1. ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7
//     -> a=5, b=7, f3=000, f7=0, rd=3, reg_write=1, out_valid 1 cycle later.
//  2. ADDI x1,x0,-1 (0xFFF00093)
//     -> b=0xFFFFFFFF, f7=0000000 despite instr[30]=1.
//     SRAI x1,x1,3 (0x4030D093)
//     -> f3=101, f7=0100000, b[4:0]=3.
//  3. AUIPC x5,0x12345 (0x12345297), pc=0x100
//     -> a=0x100, b=0x12345000, f3=000, rd=5.
//  4. out_ready=0, push 3 bundles back-to-back
//     -> in_ready drops after the 2nd accept.
//     -> Release: outputs appear in order; none lost or duplicated.
//  5. Opcode 0x03 (load), rd=4
//     -> illegal=1, reg_write=0, out_valid=1.
//     ADD with rd=0 -> reg_write=0, illegal=0.
//  6. Flush with both entries full and in_valid=1
//     -> out_valid=0 next cycle, in_ready=1, input dropped.
//     rst_n low mid-stream -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/alu_decode_if.sv
// Handshake bundle between the register-read stage, the decode/issue stage and the ALU execute stage.
// The slave modport is the decode stage's view; the master modport is the surrounding pipeline.
interface alu_decode_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [2:0]      alu_funct3;
    logic [6:0]      alu_funct7;
    logic [4:0]      rd;
    logic            reg_write;
    logic            illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, flush, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_funct3, alu_funct7, rd, reg_write, illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, flush, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_funct3, alu_funct7, rd, reg_write, illegal
    );
endinterface

// File: rtl/alu_decode_stage.sv
// RV32I decode/issue stage: turns OP, OP-IMM, LUI and AUIPC into ALU operands and controls,
// delivered through a registered output plus one skid entry so no input reaches a handshake output combinationally.
module alu_decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_decode_if.slave  bus
);

    if (XLEN != 32) begin : g_xlen_check
        $error("alu_decode_stage: only XLEN=32 is supported");
    end

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [4:0]      rd;
        logic            reg_write;
        logic            illegal;
    } bundle_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    bundle_t dec;
    logic    legal;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    bundle_t out_d, out_q, skid_d, skid_q;
    logic    out_valid_d, out_valid_q;
    logic    skid_valid_d, skid_valid_q;
    logic    in_ready_d, in_ready_q;
    logic    accept, drain;

    assign opcode = bus.in_instr[6:0];
    assign funct3 = bus.in_instr[14:12];
    assign funct7 = bus.in_instr[31:25];

    always_comb begin
        dec    = '0;
        legal  = 1'b0;
        dec.rd = bus.in_instr[11:7];
        case (opcode)
            OPC_OP: begin
                dec.a  = bus.in_rs1_data;
                dec.b  = bus.in_rs2_data;
                dec.f3 = funct3;
                dec.f7 = funct7;
                legal  = (funct7 == 7'b0) ||
                         ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                dec.a  = bus.in_rs1_data;
                dec.b  = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
                dec.f3 = funct3;
                legal  = 1'b1;
                // Only shifts carry funct7; other immediates keep it zero so ADDI never becomes SUB.
                if (funct3 == 3'b001) begin
                    dec.f7 = funct7;
                    legal  = (funct7 == 7'b0);
                end else if (funct3 == 3'b101) begin
                    dec.f7 = funct7;
                    legal  = (funct7 == 7'b0) || (funct7 == F7_ALT);
                end
            end
            OPC_LUI: begin
                dec.b = XLEN'({bus.in_instr[31:12], 12'b0});
                legal = 1'b1;
            end
            OPC_AUIPC: begin
                dec.a = XLEN'(bus.in_pc);
                dec.b = XLEN'({bus.in_instr[31:12], 12'b0});
                legal = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        dec.illegal   = !legal;
        dec.reg_write = legal && (dec.rd != 5'd0);
    end

    assign accept = bus.in_valid && in_ready_q;
    assign drain  = out_valid_q && bus.out_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (bus.flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || drain) begin
            // Skid entry is older than anything arriving now, and in_ready is low while it is held.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.alu_a      = out_q.a;
    assign bus.alu_b      = out_q.b;
    assign bus.alu_funct3 = out_q.f3;
    assign bus.alu_funct7 = out_q.f7;
    assign bus.rd         = out_q.rd;
    assign bus.reg_write  = out_q.reg_write;
    assign bus.illegal    = out_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: expected bundles are queued on accept and
// compared whenever the stage hands a bundle to execute.
module tb_alu_decode_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_decode_if #(.XLEN(32), .PC_W(32)) bus ();

    alu_decode_stage #(.XLEN(32), .PC_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_pop  = 0;
    exp_t sb_q[$];
    exp_t mon_obs, mon_exp;

    // Reference decode written straight from the instruction-set tables.
    function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc,
                                   input logic [31:0] rs1, input logic [31:0] rs2);
        exp_t e;
        bit   ok;
        e    = '0;
        ok   = 0;
        e.rd = instr[11:7];
        case (instr[6:0])
            7'h33: begin
                e.a = rs1; e.b = rs2; e.f3 = instr[14:12]; e.f7 = instr[31:25];
                ok = (instr[31:25] == 7'h00) ||
                     (instr[31:25] == 7'h20 && (instr[14:12] == 3'd0 || instr[14:12] == 3'd5));
            end
            7'h13: begin
                e.a = rs1; e.b = {{20{instr[31]}}, instr[31:20]}; e.f3 = instr[14:12];
                case (instr[14:12])
                    3'd1:    begin e.f7 = instr[31:25]; ok = (instr[31:25] == 7'h00); end
                    3'd5:    begin e.f7 = instr[31:25]; ok = (instr[31:25] == 7'h00 || instr[31:25] == 7'h20); end
                    default: ok = 1;
                endcase
            end
            7'h37: begin e.b = {instr[31:12], 12'h000}; ok = 1; end
            7'h17: begin e.a = pc; e.b = {instr[31:12], 12'h000}; ok = 1; end
            default: ok = 0;
        endcase
        e.ill = !ok;
        e.rw  = ok && (instr[11:7] != 5'd0);
        return e;
    endfunction

    function automatic exp_t observed();
        return {bus.alu_a, bus.alu_b, bus.alu_funct3, bus.alu_funct7, bus.rd, bus.reg_write, bus.illegal};
    endfunction

    // Scoreboard: a bundle leaves the stage on any edge with out_valid && out_ready and no flush.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready && !bus.flush) begin
            mon_obs = observed();
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL sb_extra: got bundle %h, required none", mon_obs);
            end else begin
                mon_exp = sb_q.pop_front();
                n_pop++;
                if (mon_obs !== mon_exp) begin
                    n_fail++;
                    $display("[TB] FAIL sb_bundle: got %h, required %h", mon_obs, mon_exp);
                end
            end
        end
    end

    // Called and returning at posedge+1; holds in_valid until the stage takes the word.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2);
        bit ok = 0;
        bus.in_valid    = 1'b1;
        bus.in_instr    = instr;
        bus.in_pc       = pc;
        bus.in_rs1_data = rs1;
        bus.in_rs2_data = rs2;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1;
                if (!bus.flush) sb_q.push_back(model(instr, pc, rs1, rs2));
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL send_timeout: in_ready got 0 for 60 cycles, required 1 (instr %h)", instr);
        end
    endtask

    task automatic drain_wait(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain: got %0d bundles pending, required 0", sb_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.in_valid = 0; bus.flush = 0; bus.out_ready = 0;
        bus.in_instr = 0; bus.in_pc = 0; bus.in_rs1_data = 0; bus.in_rs2_data = 0;
        #1 rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({bus.out_valid, bus.in_ready, observed()} !== {1'b0, 1'b1, 81'd0}) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got v=%b r=%b %h, required v=0 r=1 0",
                     bus.out_valid, bus.in_ready, observed());
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add_latency();
        bus.out_ready = 1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL add_pre_valid: got %b, required 0", bus.out_valid);
        end
        send(32'h002081B3, 32'h0, 32'd5, 32'd7);
        n_cmp++;
        if ({bus.out_valid, observed()} !== {1'b1, 32'd5, 32'd7, 3'd0, 7'd0, 5'd3, 1'b1, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL add_bundle: got v=%b %h, required v=1 a=5 b=7 rd=3 rw=1",
                     bus.out_valid, observed());
        end
        drain_wait(10);
    endtask

    task automatic test_op_imm();
        bus.out_ready = 1;
        send(32'hFFF00093, 32'h0, 32'h0, 32'h0);
        n_cmp++;
        if ({bus.alu_b, bus.alu_funct7} !== {32'hFFFFFFFF, 7'h00}) begin
            n_fail++;
            $display("[TB] FAIL addi_neg: got b=%h f7=%h, required b=ffffffff f7=00", bus.alu_b, bus.alu_funct7);
        end
        send(32'h4030D093, 32'h0, 32'h80000000, 32'h0);
        n_cmp++;
        if ({bus.alu_funct3, bus.alu_funct7, bus.alu_b[4:0]} !== {3'b101, 7'b0100000, 5'd3}) begin
            n_fail++;
            $display("[TB] FAIL srai: got f3=%b f7=%b sh=%0d, required f3=101 f7=0100000 sh=3",
                     bus.alu_funct3, bus.alu_funct7, bus.alu_b[4:0]);
        end
        send(32'h40109093, 32'h0, 32'h1, 32'h0);
        n_cmp++;
        if (bus.illegal !== 1'b1) begin
            n_fail++; $display("[TB] FAIL slli_bad_f7: got illegal=%b, required 1", bus.illegal);
        end
        drain_wait(10);
    endtask

    task automatic test_auipc_lui();
        bus.out_ready = 1;
        send(32'h12345297, 32'h100, 32'hDEAD, 32'hBEEF);
        n_cmp++;
        if ({bus.alu_a, bus.alu_b, bus.alu_funct3, bus.rd} !== {32'h100, 32'h12345000, 3'd0, 5'd5}) begin
            n_fail++;
            $display("[TB] FAIL auipc: got a=%h b=%h f3=%0d rd=%0d, required a=100 b=12345000 f3=0 rd=5",
                     bus.alu_a, bus.alu_b, bus.alu_funct3, bus.rd);
        end
        send(32'hABCDE0B7, 32'h200, 32'h1234, 32'h0);
        n_cmp++;
        if ({bus.alu_a, bus.alu_b} !== {32'h0, 32'hABCDE000}) begin
            n_fail++;
            $display("[TB] FAIL lui: got a=%h b=%h, required a=0 b=abcde000", bus.alu_a, bus.alu_b);
        end
        drain_wait(10);
    endtask

    task automatic test_back_to_back();
        int pops0;
        pops0 = n_pop;
        bus.out_ready = 0;
        send(32'h002081B3, 32'h0, 32'd1, 32'd2);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL b2b_ready1: got %b, required 1", bus.in_ready);
        end
        send(32'h40208233, 32'h0, 32'd10, 32'd3);
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("[TB] FAIL b2b_ready2: got %b, required 0", bus.in_ready);
        end
        fork
            send(32'h00A00293, 32'h0, 32'd100, 32'd0);
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1;
            end
        join
        drain_wait(20);
        n_cmp++;
        if (n_pop - pops0 != 3) begin
            n_fail++; $display("[TB] FAIL b2b_count: got %0d delivered, required 3", n_pop - pops0);
        end
    endtask

    task automatic test_illegal();
        bus.out_ready = 1;
        send(32'h00002203, 32'h0, 32'h55, 32'h66);
        n_cmp++;
        if ({bus.out_valid, bus.illegal, bus.reg_write, bus.rd} !== {1'b1, 1'b1, 1'b0, 5'd4}) begin
            n_fail++;
            $display("[TB] FAIL load_illegal: got v=%b ill=%b rw=%b rd=%0d, required v=1 ill=1 rw=0 rd=4",
                     bus.out_valid, bus.illegal, bus.reg_write, bus.rd);
        end
        send(32'h00208033, 32'h0, 32'd1, 32'd2);
        n_cmp++;
        if ({bus.illegal, bus.reg_write} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL add_rd0: got ill=%b rw=%b, required ill=0 rw=0", bus.illegal, bus.reg_write);
        end
        send(32'h402091B3, 32'h0, 32'd1, 32'd2);
        n_cmp++;
        if ({bus.illegal, bus.reg_write} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL sll_f7: got ill=%b rw=%b, required ill=1 rw=0", bus.illegal, bus.reg_write);
        end
        drain_wait(10);
    endtask

    task automatic test_flush();
        bus.out_ready = 0;
        send(32'h002081B3, 32'h0, 32'd1, 32'd1);
        send(32'h002081B3, 32'h0, 32'd2, 32'd2);
        for (int s = 0; s < 2; s++) begin
            bus.in_valid = 1; bus.in_instr = 32'h00300113; bus.flush = 1;
            @(posedge clk);
            #1;
            bus.flush = 0; bus.in_valid = 0;
            sb_q.delete();
            n_cmp++;
            if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
                n_fail++;
                $display("[TB] FAIL flush_%0d: got v=%b r=%b, required v=0 r=1", s, bus.out_valid, bus.in_ready);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++; $display("[TB] FAIL flush_drop_%0d: got v=%b, required 0", s, bus.out_valid);
            end
            if (s == 0) send(32'h002081B3, 32'h0, 32'd3, 32'd3);
        end
        bus.out_ready = 1;
        send(32'h00500093, 32'h0, 32'd9, 32'd0);
        drain_wait(10);
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 0;
        send(32'h002081B3, 32'h0, 32'd4, 32'd4);
        send(32'h12345297, 32'h44, 32'd0, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        sb_q.delete();
        n_cmp++;
        if ({bus.out_valid, bus.in_ready, observed()} !== {1'b0, 1'b1, 81'd0}) begin
            n_fail++;
            $display("[TB] FAIL reset_mid: got v=%b r=%b %h, required v=0 r=1 0",
                     bus.out_valid, bus.in_ready, observed());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random_backpressure();
        bit          done = 0;
        logic [31:0] r;
        logic [6:0]  ops[6] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h63};
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    r = $urandom();
                    if ($urandom_range(0, 1) == 1) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                    send({r[31:7], ops[$urandom_range(0, 5)]}, $urandom(), $urandom(), $urandom());
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        bus.out_ready = 1;
        drain_wait(20);
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_op_imm();
        test_auipc_lui();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_reset_mid();
        test_random_backpressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion by 200000, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
